// File: rtl/conv_top.sv
// conv_top: streaming K x K valid-mode 2-D convolution over a raster pixel stream.
// Optional CONV_TOP_RELU_EN clamps negative results to zero.
module conv_top #(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int K      = 3,
  parameter int DATA_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         valid_pixel,
  input  logic [DATA_W-1:0]            pixel_in,
  input  logic [DATA_W*K*K-1:0]        kernel_flat,
  output logic [2*DATA_W+8:0]          conv_out,
  output logic                         valid_out
);
  localparam int OW = 2*DATA_W+9;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic signed [DATA_W-1:0] lb [K-1][IMG_W];
  logic signed [DATA_W-1:0] win [K][K-1];
  logic signed [DATA_W-1:0] col_vec [K];
  logic signed [DATA_W-1:0] wf [K][K];
  logic signed [2*DATA_W-1:0] p;
  logic signed [OW-1:0] acc, res;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic col_last;
  assign col_last = col == CW'(IMG_W-1);
  // lb[k][c] holds row r-1-k at column c; the incoming pixel completes the newest column
  always_comb begin
    col_vec[K-1] = pixel_in;
    for (int i = 0; i < K-1; i++) col_vec[i] = lb[K-2-i][col];
    for (int i = 0; i < K; i++) begin
      wf[i][K-1] = col_vec[i];
      for (int j = 0; j < K-1; j++) wf[i][j] = win[i][j];
    end
    acc = '0;
    p = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) begin
        p = $signed(kernel_flat[(i*K+j)*DATA_W +: DATA_W]) * wf[i][j];
        acc = acc + OW'(p);
      end
`ifdef CONV_TOP_RELU_EN
    res = acc[OW-1] ? '0 : acc;
`else
    res = acc;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      conv_out <= '0;
      valid_out <= 1'b0;
      for (int k = 0; k < K-1; k++)
        for (int c = 0; c < IMG_W; c++) lb[k][c] <= '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K-1; j++) win[i][j] <= '0;
    end else begin
      valid_out <= 1'b0;
      if (valid_pixel) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) row <= (row == RW'(IMG_H-1)) ? '0 : row + 1'b1;
        lb[0][col] <= pixel_in;
        for (int k = 1; k < K-1; k++) lb[k][col] <= lb[k-1][col];
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K-2; j++) win[i][j] <= win[i][j+1];
          win[i][K-2] <= col_vec[i];
        end
        if (row >= RW'(K-1) && col >= CW'(K-1)) begin
          conv_out <= res;
          valid_out <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_top.sv
// tb_conv_top: randomized self-checking bench for conv_top against a frame-level model.
module tb_conv_top;
  localparam int W = 5, H = 5, K = 3, D = 8, OW = 2*D+9;
  logic clk = 1'b0, rst_n = 1'b0, valid_pixel = 1'b0;
  logic [D-1:0] pixel_in = '0;
  logic [D*K*K-1:0] kernel_flat = '0;
  logic [OW-1:0] conv_out;
  logic valid_out;
  int total = 0, bad = 0;
  int img [H][W];
  int wt [K][K];
  int last_out = 0;
  always #5 clk = ~clk;
  conv_top #(.IMG_W(W), .IMG_H(H), .K(K), .DATA_W(D)) dut (
    .clk(clk), .rst_n(rst_n), .valid_pixel(valid_pixel), .pixel_in(pixel_in),
    .kernel_flat(kernel_flat), .conv_out(conv_out), .valid_out(valid_out));
  function automatic int expect_at(int r0, int c0);
    int s = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) s += wt[i][j] * img[r0+i][c0+j];
`ifdef CONV_TOP_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction
  task automatic load_kernel();
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) kernel_flat[(i*K+j)*D +: D] = D'(wt[i][j]);
  endtask
  task automatic fill(input int mode, input int a);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = mode == 0 ? r*W + c + 1 : mode == 1 ? a : int'($urandom_range(0, 255)) - 128;
  endtask
  task automatic weights(input int mode, input int a);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        wt[i][j] = mode == 0 ? a : mode == 1 ? int'(i == 1 && j == 1) : int'($urandom_range(0, 255)) - 128;
    load_kernel();
  endtask
  task automatic drive_frame(input string name, input int gap_pct, input int npix);
    int exp_v;
    for (int n = 0; n < npix; n++) begin
      int r = n / W, c = n % W;
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        @(negedge clk) valid_pixel = 1'b0;
        @(posedge clk) #1;
        total++;
        if (valid_out !== 1'b0 || conv_out !== OW'(last_out)) begin
          bad++;
          $display("FAIL %s gap r%0d c%0d: valid=%b out=%0d, need valid=0 out=%0d", name, r, c, valid_out, $signed(conv_out), last_out);
        end
      end
      @(negedge clk) begin valid_pixel = 1'b1; pixel_in = D'(img[r][c]); end
      @(posedge clk) #1;
      total++;
      if (r >= K-1 && c >= K-1) begin
        exp_v = expect_at(r-K+1, c-K+1);
        if (valid_out !== 1'b1 || conv_out !== OW'(exp_v)) begin
          bad++;
          $display("FAIL %s result r%0d c%0d: valid=%b out=%0d, need valid=1 out=%0d", name, r, c, valid_out, $signed(conv_out), exp_v);
        end
        last_out = exp_v;
      end else if (valid_out !== 1'b0) begin
        bad++;
        $display("FAIL %s early r%0d c%0d: valid=%b, need 0", name, r, c, valid_out);
      end
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk) valid_pixel = 1'b0;
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 total++;
    if (conv_out !== '0 || valid_out !== 1'b0) begin
      bad++;
      $display("FAIL reset: out=%0d valid=%b, need 0 0", $signed(conv_out), valid_out);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask
  task automatic test_ramp();
    fill(0, 0); weights(0, 1);
    drive_frame("ramp", 0, W*H); idle(2);
    total++;
    if (conv_out !== OW'(171)) begin
      bad++;
      $display("FAIL ramp_final: out=%0d, need 171", $signed(conv_out));
    end
  endtask
  task automatic test_gaps();
    fill(0, 0); weights(0, 1);
    drive_frame("gaps", 40, W*H); idle(2);
  endtask
  task automatic test_extremes();
    fill(1, -128); weights(0, -128);
    drive_frame("neg_neg", 0, W*H); idle(1);
    weights(0, 127);
    drive_frame("neg_pos", 20, W*H); idle(1);
  endtask
  task automatic test_identity();
    fill(0, 0); weights(1, 0);
    drive_frame("identity", 0, W*H); idle(1);
  endtask
  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      fill(2, 0); weights(2, 0);
      drive_frame("random", 25, W*H);
    end
    idle(1);
  endtask
  task automatic test_back_to_back();
    fill(0, 0); weights(0, 1);
    drive_frame("b2b_first", 0, W*H);
    drive_frame("b2b_second", 0, W*H); idle(1);
  endtask
  task automatic test_mid_reset();
    fill(2, 0); weights(2, 0);
    drive_frame("pre_reset", 0, 3*W + 2);
    @(negedge clk) begin valid_pixel = 1'b0; rst_n = 1'b0; end
    #1 total++;
    if (conv_out !== '0 || valid_out !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_clear: out=%0d valid=%b, need 0 0", $signed(conv_out), valid_out);
    end
    @(negedge clk) rst_n = 1'b1;
    last_out = 0;
    fill(2, 0);
    drive_frame("post_reset", 10, W*H); idle(1);
  endtask
  initial begin
    test_reset();
    test_ramp();
    test_gaps();
    test_extremes();
    test_identity();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
